mult_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO result registers. It replaces the separate fixed-width multiplier and divider in the multicycle datapath. It adds signed/unsigned modes, a start/busy/done handshake, divide-by-zero detection, and an optional abort. The control unit issues one operation at a time and reads `hi`/`lo` after `done`.

---
 rtl/mult_div_unit_if.sv | 30 +++
 rtl/mult_div_unit.sv | 103 ++++++++++
 tb/tb_mult_div_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: start/busy/done handshake, operands and HI/LO results of mult_div_unit.
// i_abort exists only when MULT_DIV_ABORT_EN is defined.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
`ifdef MULT_DIV_ABORT_EN
    logic             i_abort;
`endif
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_div_zero;
    modport slave (
        input  i_start, i_op, i_a, i_b,
`ifdef MULT_DIV_ABORT_EN
        input  i_abort,
`endif
        output o_busy, o_done, o_hi, o_lo, o_div_zero
    );
    modport master (
        output i_start, i_op, i_a, i_b,
`ifdef MULT_DIV_ABORT_EN
        output i_abort,
`endif
        input  o_busy, o_done, o_hi, o_lo, o_div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply (shift-add) and restoring divide with HI/LO results.
// Define MULT_DIV_ABORT_EN to add the i_abort cancel input.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            i_clock,
    input logic            i_reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             r_state;
    logic [1:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic               r_sa, r_sb, r_zero;
    logic               r_busy, r_done, r_dz;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               w_neg_a, w_neg_b, w_zero;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem;
    logic [WIDTH:0]     w_sum, w_shift, w_diff;
    logic [2*WIDTH-1:0] w_mul, w_div, w_prod;
    always_comb begin
        w_neg_a = ~bus.i_op[0] & bus.i_a[WIDTH-1];
        w_neg_b = ~bus.i_op[0] & bus.i_b[WIDTH-1];
        w_mag_a = w_neg_a ? -bus.i_a : bus.i_a;
        w_mag_b = w_neg_b ? -bus.i_b : bus.i_b;
        w_zero  = bus.i_op[1] & (bus.i_b == '0);
        // r_acc low half holds the multiplier (mult) or the dividend shifting into quotient (div)
        w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
        w_mul   = {w_sum, r_acc[WIDTH-1:1]};
        w_shift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_m};
        w_div   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
        w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_quo   = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem   = r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    end
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
`ifdef MULT_DIV_ABORT_EN
            if (r_state != IDLE && bus.i_abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else
`endif
            case (r_state)
                IDLE: if (bus.i_start) begin
                    r_op    <= bus.i_op;
                    r_cnt   <= CW'(WIDTH);
                    r_dz    <= 1'b0;
                    r_sa    <= w_neg_a;
                    r_sb    <= w_neg_b;
                    r_zero  <= w_zero;
                    r_rem   <= '0;
                    r_m     <= bus.i_op[1] ? w_mag_b : w_mag_a;
                    // divide-by-zero keeps the raw dividend so FIX can return it in hi
                    r_acc   <= {{WIDTH{1'b0}}, w_zero ? bus.i_a : (bus.i_op[1] ? w_mag_a : w_mag_b)};
                    r_busy  <= ~w_zero;
                    r_state <= w_zero ? FIX : CALC;
                end
                CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_acc <= r_op[1] ? w_div : w_mul;
                    r_rem <= w_diff[WIDTH] ? w_shift : w_diff;
                    if (r_cnt == CW'(1)) r_state <= FIX;
                end
                FIX: begin
                    r_hi    <= r_zero ? r_acc[WIDTH-1:0] : (r_op[1] ? w_rem : w_prod[2*WIDTH-1:WIDTH]);
                    r_lo    <= r_zero ? '1 : (r_op[1] ? w_quo : w_prod[WIDTH-1:0]);
                    r_dz    <= r_zero;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_hi       = r_hi;
    assign bus.o_lo       = r_lo;
    assign bus.o_div_zero = r_dz;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard-driven bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mult_div_unit_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.i_clock(clk), .i_reset(rst_n), .bus(bus.slave));
    logic [64:0] sb [$];
    int pass_cnt = 0;
    int total = 0;

    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb_ = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] p, q, r;
        if (op[1] && b == 0) return {1'b1, a, 32'hFFFFFFFF};
        case (op)
            2'b00: p = sa * sb_;
            2'b01: p = ua * ub;
            2'b10: begin q = sa / sb_; r = sa % sb_; p = {r[31:0], q[31:0]}; end
            default: begin q = ua / ub; r = ua % ub; p = {r[31:0], q[31:0]}; end
        endcase
        return {1'b0, p};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [64:0] exp);
        bus.i_start = 1'b1;
        bus.i_op = op;
        bus.i_a = a;
        bus.i_b = b;
        sb.push_back(exp);
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = bus.o_busy ? 1 : 0;
        while (!bus.o_done && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.o_busy) busy_n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_hi, bus.o_lo} !== 67'd0)
            $display("FAIL reset_state got=%h want=0", {bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_hi, bus.o_lo});
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int n, bn;
        logic [64:0] exp;
        issue(2'b00, 32'hFFFFFFFD, 32'd7, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
        wait_done(n, bn);
        exp = sb.pop_front();
        total++;
        if (!bus.o_done || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== exp)
            $display("FAIL mult_result got=%h want=%h", {bus.o_div_zero, bus.o_hi, bus.o_lo}, exp);
        else pass_cnt++;
        total++;
        if (n !== 33) $display("FAIL mult_latency got=%0d want=33", n); else pass_cnt++;
        total++;
        if (bn !== 33) $display("FAIL mult_busy_cycles got=%0d want=33", bn); else pass_cnt++;
        @(negedge clk);
        total++;
        if (bus.o_done !== 1'b0) $display("FAIL done_pulse got=%b want=0", bus.o_done); else pass_cnt++;
    endtask

    task automatic test_multu_ignore;
        int n, bn;
        logic [64:0] exp;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001});
        repeat (5) @(negedge clk);
        bus.i_start = 1'b1; bus.i_op = 2'b10; bus.i_a = 32'd5; bus.i_b = 32'd3;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_done(n, bn);
        exp = sb.pop_front();
        total++;
        if (!bus.o_done || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== exp)
            $display("FAIL multu_result got=%h want=%h", {bus.o_div_zero, bus.o_hi, bus.o_lo}, exp);
        else pass_cnt++;
        total++;
        if (n + 6 !== 33) $display("FAIL multu_latency got=%0d want=33", n + 6); else pass_cnt++;
        @(negedge clk);
        total++;
        if ({bus.o_busy, bus.o_done} !== 2'b00) $display("FAIL ignored_start got=%b want=00", {bus.o_busy, bus.o_done}); else pass_cnt++;
    endtask

    task automatic test_div_back_to_back;
        int n, bn;
        logic [64:0] exp;
        issue(2'b10, 32'hFFFFFFF9, 32'd2, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
        repeat (10) @(negedge clk);
        total++;
        if ({bus.o_hi, bus.o_lo} !== {32'hFFFFFFFE, 32'h00000001})
            $display("FAIL hold_during_calc got=%h want=%h", {bus.o_hi, bus.o_lo}, {32'hFFFFFFFE, 32'h00000001});
        else pass_cnt++;
        wait_done(n, bn);
        exp = sb.pop_front();
        total++;
        if (!bus.o_done || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== exp)
            $display("FAIL div_signed got=%h want=%h", {bus.o_div_zero, bus.o_hi, bus.o_lo}, exp);
        else pass_cnt++;
        issue(2'b11, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
        wait_done(n, bn);
        exp = sb.pop_front();
        total++;
        if (!bus.o_done || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== exp)
            $display("FAIL divu_b2b got=%h want=%h", {bus.o_div_zero, bus.o_hi, bus.o_lo}, exp);
        else pass_cnt++;
        total++;
        if (n !== 33) $display("FAIL b2b_latency got=%0d want=33", n); else pass_cnt++;
    endtask

    task automatic test_div_zero;
        int n, bn;
        logic [64:0] exp;
        issue(2'b11, 32'd100, 32'd0, {1'b1, 32'd100, 32'hFFFFFFFF});
        wait_done(n, bn);
        exp = sb.pop_front();
        total++;
        if (!bus.o_done || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== exp)
            $display("FAIL div_zero_result got=%h want=%h", {bus.o_div_zero, bus.o_hi, bus.o_lo}, exp);
        else pass_cnt++;
        total++;
        if (n !== 1 || bn !== 0) $display("FAIL div_zero_timing got=%0d/%0d want=1/0", n, bn); else pass_cnt++;
        issue(2'b00, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6});
        total++;
        if (bus.o_div_zero !== 1'b0) $display("FAIL div_zero_clear got=%b want=0", bus.o_div_zero); else pass_cnt++;
        wait_done(n, bn);
        exp = sb.pop_front();
        total++;
        if (!bus.o_done || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== exp)
            $display("FAIL mult_after_dz got=%h want=%h", {bus.o_div_zero, bus.o_hi, bus.o_lo}, exp);
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        int n, bn;
        logic [64:0] exp;
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h0, 32'h80000000});
        wait_done(n, bn);
        exp = sb.pop_front();
        total++;
        if (!bus.o_done || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== exp)
            $display("FAIL div_overflow got=%h want=%h", {bus.o_div_zero, bus.o_hi, bus.o_lo}, exp);
        else pass_cnt++;
    endtask

    task automatic test_random;
        int n, bn;
        logic [1:0] op;
        logic [31:0] a, b;
        logic [64:0] exp;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            issue(op, a, b, model(op, a, b));
            wait_done(n, bn);
            exp = sb.pop_front();
            total++;
            if (!bus.o_done || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== exp)
                $display("FAIL random_%0d op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, {bus.o_div_zero, bus.o_hi, bus.o_lo}, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        logic saw;
        issue(2'b00, 32'd1234, 32'd5678, 65'd0);
        void'(sb.pop_back());
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_hi, bus.o_lo} !== 67'd0)
            $display("FAIL reset_mid got=%h want=0", {bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_hi, bus.o_lo});
        else pass_cnt++;
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) saw = 1'b1;
        end
        total++;
        if (saw !== 1'b0) $display("FAIL reset_no_done got=%b want=0", saw); else pass_cnt++;
    endtask

`ifdef MULT_DIV_ABORT_EN
    task automatic test_abort;
        int n, bn;
        logic saw;
        logic [64:0] exp;
        bus.i_abort = 1'b1;
        issue(2'b01, 32'd6, 32'd7, {1'b0, 32'd0, 32'd42});
        bus.i_abort = 1'b0;
        wait_done(n, bn);
        exp = sb.pop_front();
        total++;
        if (!bus.o_done || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== exp)
            $display("FAIL abort_idle got=%h want=%h", {bus.o_div_zero, bus.o_hi, bus.o_lo}, exp);
        else pass_cnt++;
        issue(2'b01, 32'd9, 32'd9, 65'd0);
        void'(sb.pop_back());
        repeat (5) @(negedge clk);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        total++;
        if (bus.o_busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", bus.o_busy); else pass_cnt++;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done) saw = 1'b1;
        end
        total++;
        if (saw || {bus.o_div_zero, bus.o_hi, bus.o_lo} !== {1'b0, 32'd0, 32'd42})
            $display("FAIL abort_hold got=%b/%h want=0/%h", saw, {bus.o_div_zero, bus.o_hi, bus.o_lo}, {1'b0, 32'd0, 32'd42});
        else pass_cnt++;
    endtask
`endif

    initial begin
        bus.i_start = 1'b0;
        bus.i_op = 2'b00;
        bus.i_a = '0;
        bus.i_b = '0;
`ifdef MULT_DIV_ABORT_EN
        bus.i_abort = 1'b0;
`endif
        @(negedge clk);
        test_reset;
        test_mult;
        test_multu_ignore;
        test_div_back_to_back;
        test_div_zero;
        test_overflow;
        test_random;
        test_reset_mid;
`ifdef MULT_DIV_ABORT_EN
        test_abort;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
